// File: rtl/sensor_framer.sv
// Sensor sample FIFO and ASCII frame serialiser for the FTDI byte link.
// Define SENSOR_FRAMER_CHECKSUM_EN to append a two-digit hex checksum.
module sensor_framer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ID_WIDTH   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [ID_WIDTH-1:0] sample_id,
   input  logic [7:0]          sample_data,
   output logic                sample_ready,
   output logic [7:0]          tx_data,
   output logic                tx_start,
   input  logic                tx_ready,
   input  logic                tx_done,
   output logic                busy,
   output logic                overflow,
   output logic [7:0]          frame_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef SENSOR_FRAMER_CHECKSUM_EN
   localparam logic [3:0] LAST_IDX = 4'd8;
`else
   localparam logic [3:0] LAST_IDX = 4'd6;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [ID_WIDTH-1:0] id_mem  [FIFO_DEPTH];
   logic [7:0]          dat_mem [FIFO_DEPTH];
   logic [PW-1:0]       wptr, rptr;
   logic [CW-1:0]       count;
   logic                full, empty, push, pop;

   logic [ID_WIDTH-1:0] fr_id;
   logic [7:0]          fr_data;
   logic [3:0]          idx;
   logic                start_nxt, idx_inc, frame_end;
   logic [7:0]          byte_sel;
   logic [7:0]          id8;

   function automatic logic [7:0] hex(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign sample_ready = !full;
   assign push         = sample_valid && !full;
   assign busy         = (state != S_IDLE) || !empty;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start_nxt = 1'b0;
      idx_inc   = 1'b0;
      frame_end = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!empty && tx_ready) begin
               pop       = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: state_nxt = S_SEND;
         S_SEND: begin
            if (tx_ready) begin
               start_nxt = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               if (idx == LAST_IDX) begin
                  frame_end = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  idx_inc   = 1'b1;
                  state_nxt = S_LOAD;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign id8 = 8'(fr_id);

   always_comb begin
      byte_sel = 8'h00;
      case (idx)
         4'd0: byte_sel = 8'h53;
         4'd1: byte_sel = hex(id8[3:0]);
         4'd2: byte_sel = 8'h3A;
         4'd3: byte_sel = hex(fr_data[7:4]);
         4'd4: byte_sel = hex(fr_data[3:0]);
`ifdef SENSOR_FRAMER_CHECKSUM_EN
         4'd5: byte_sel = hex(id8[7:4] ^ fr_data[7:4]);
         4'd6: byte_sel = hex(id8[3:0] ^ fr_data[3:0]);
         4'd7: byte_sel = 8'h0D;
         4'd8: byte_sel = 8'h0A;
`else
         4'd5: byte_sel = 8'h0D;
         4'd6: byte_sel = 8'h0A;
`endif
         default: byte_sel = 8'h00;
      endcase
   end

   // Storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wptr]  <= sample_id;
         dat_mem[wptr] <= sample_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         fr_id       <= '0;
         fr_data     <= 8'h00;
         idx         <= 4'd0;
         tx_data     <= 8'h00;
         tx_start    <= 1'b0;
         overflow    <= 1'b0;
         frame_count <= 8'h00;
      end else begin
         state    <= state_nxt;
         tx_start <= start_nxt;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         if (sample_valid && full) overflow <= 1'b1;
         if (pop) begin
            fr_id   <= id_mem[rptr];
            fr_data <= dat_mem[rptr];
            idx     <= 4'd0;
         end
         if (idx_inc) idx <= idx + 4'd1;
         if (state == S_LOAD) tx_data <= byte_sel;
         if (frame_end) frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_sensor_framer.sv
// Directed self-checking bench for sensor_framer with a simple FTDI model.
// Honours SENSOR_FRAMER_CHECKSUM_EN for the 9-byte frame variant.
module tb_sensor_framer;

`ifdef SENSOR_FRAMER_CHECKSUM_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 7;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sample_valid = 1'b0;
   logic [3:0] sample_id = 4'h0;
   logic [7:0] sample_data = 8'h00;
   logic       sample_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready = 1'b1;
   logic       tx_done;
   logic       busy;
   logic       overflow;
   logic [7:0] frame_count;

   logic       model_done = 1'b0;
   logic       spur_done = 1'b0;
   int         done_delay = 10;
   int         starts = 0;
   int         done_cnt = 0;
   logic [7:0] cap[$];

   int checks = 0;
   int errors = 0;

   assign tx_done = model_done | spur_done;

   always #10 clk = ~clk;

   sensor_framer #(.FIFO_DEPTH(4), .ID_WIDTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .sample_valid(sample_valid),
      .sample_id(sample_id),
      .sample_data(sample_data),
      .sample_ready(sample_ready),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .tx_ready(tx_ready),
      .tx_done(tx_done),
      .busy(busy),
      .overflow(overflow),
      .frame_count(frame_count)
   );

   // FTDI stand-in: latch the byte on tx_start, answer after done_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start) begin
            cap.push_back(tx_data);
            starts++;
            repeat (done_delay - 1) @(negedge clk);
            model_done = 1'b1;
            done_cnt++;
            @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   function automatic logic [7:0] hx(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return 8'h41 + {4'h0, n} - 8'd10;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [3:0] id,
                                           input logic [7:0] d,
                                           input int k);
      logic [7:0] c;
      logic [7:0] f[9];
      c = {4'h0, id} ^ d;
      f[0] = 8'h53;
      f[1] = hx(id);
      f[2] = 8'h3A;
      f[3] = hx(d[7:4]);
      f[4] = hx(d[3:0]);
      if (FLEN == 9) begin
         f[5] = hx(c[7:4]);
         f[6] = hx(c[3:0]);
         f[7] = 8'h0D;
         f[8] = 8'h0A;
      end else begin
         f[5] = 8'h0D;
         f[6] = 8'h0A;
         f[7] = 8'h00;
         f[8] = 8'h00;
      end
      return f[k];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic push(input logic [3:0] id, input logic [7:0] d);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_id    = id;
      sample_data  = d;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s timeout busy=%b after %0d cycles", nm, busy, n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (sample_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready got %b exp 1", sample_ready);
      end
      if (tx_start !== 1'b0) begin
         errors++; $display("FAIL rst_start got %b exp 0", tx_start);
      end
      if (tx_data !== 8'h00) begin
         errors++; $display("FAIL rst_data got %h exp 00", tx_data);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL rst_ovf got %b exp 0", overflow);
      end
      if (frame_count !== 8'h00) begin
         errors++; $display("FAIL rst_fc got %h exp 00", frame_count);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy got %b exp 0", busy);
      end
   endtask

   task automatic test_format();
      logic [7:0] ex[FLEN];
      int cb, sb;
`ifdef SENSOR_FRAMER_CHECKSUM_EN
      ex = '{8'h53, 8'h30, 8'h3A, 8'h33, 8'h46, 8'h33, 8'h46, 8'h0D, 8'h0A};
`else
      ex = '{8'h53, 8'h30, 8'h3A, 8'h33, 8'h46, 8'h0D, 8'h0A};
`endif
      do_reset();
      done_delay = 10;
      tx_ready = 1'b1;
      cb = cap.size();
      sb = starts;
      @(negedge clk);
      sample_valid = 1'b1;
      sample_id    = 4'h0;
      sample_data  = 8'h3F;
      @(negedge clk);
      sample_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL fmt_busy got %b exp 1", busy);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_start !== 1'b0) begin
            errors++; $display("FAIL fmt_lat_early%0d got %b exp 0", i, tx_start);
         end
         @(negedge clk);
      end
      checks += 2;
      if (tx_start !== 1'b1) begin
         errors++; $display("FAIL fmt_lat got %b exp 1", tx_start);
      end
      if (tx_data !== 8'h53) begin
         errors++; $display("FAIL fmt_first got %h exp 53", tx_data);
      end
      wait_idle(2000, "fmt_idle");
      checks += 2;
      if (starts - sb !== FLEN) begin
         errors++; $display("FAIL fmt_starts got %0d exp %0d", starts - sb, FLEN);
      end
      if (frame_count !== 8'h01) begin
         errors++; $display("FAIL fmt_fc got %h exp 01", frame_count);
      end
      for (int k = 0; k < FLEN; k++) begin
         checks++;
         if (cap.size() <= cb + k || cap[cb+k] !== ex[k]) begin
            errors++;
            $display("FAIL fmt_byte%0d got %h exp %h", k,
                     (cap.size() > cb + k) ? cap[cb+k] : 8'hxx, ex[k]);
         end
      end
   endtask

   task automatic test_hex_letters();
      logic [7:0] ex[FLEN];
      int cb;
`ifdef SENSOR_FRAMER_CHECKSUM_EN
      ex = '{8'h53, 8'h32, 8'h3A, 8'h41, 8'h35, 8'h41, 8'h37, 8'h0D, 8'h0A};
`else
      ex = '{8'h53, 8'h32, 8'h3A, 8'h41, 8'h35, 8'h0D, 8'h0A};
`endif
      do_reset();
      cb = cap.size();
      push(4'h2, 8'hA5);
      wait_idle(2000, "hex_idle");
      for (int k = 0; k < FLEN; k++) begin
         checks++;
         if (cap.size() <= cb + k || cap[cb+k] !== ex[k]) begin
            errors++;
            $display("FAIL hex_byte%0d got %h exp %h", k,
                     (cap.size() > cb + k) ? cap[cb+k] : 8'hxx, ex[k]);
         end
      end
   endtask

   task automatic test_overflow();
      int cb, sb;
      logic [7:0] e;
      do_reset();
      done_delay = 3;
      tx_ready = 1'b0;
      cb = cap.size();
      sb = starts;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (sample_ready !== (i < 4)) begin
            errors++;
            $display("FAIL ovf_ready%0d got %b exp %b", i, sample_ready, i < 4);
         end
         sample_valid = 1'b1;
         sample_id    = 4'(i);
         sample_data  = {4'(i), ~4'(i)};
      end
      @(negedge clk);
      sample_valid = 1'b0;
      checks += 2;
      if (sample_ready !== 1'b0) begin
         errors++; $display("FAIL ovf_full got %b exp 0", sample_ready);
      end
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_flag got %b exp 1", overflow);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      wait_idle(5000, "ovf_idle");
      checks += 3;
      if (frame_count !== 8'd4) begin
         errors++; $display("FAIL ovf_fc got %0d exp 4", frame_count);
      end
      if (starts - sb !== 4 * FLEN) begin
         errors++; $display("FAIL ovf_starts got %0d exp %0d", starts - sb, 4 * FLEN);
      end
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got %b exp 1", overflow);
      end
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < FLEN; k++) begin
            e = exp_byte(4'(f), {4'(f), ~4'(f)}, k);
            checks++;
            if (cap.size() <= cb + f * FLEN + k || cap[cb+f*FLEN+k] !== e) begin
               errors++;
               $display("FAIL ovf_f%0d_b%0d got %h exp %h", f, k,
                        (cap.size() > cb + f * FLEN + k) ? cap[cb+f*FLEN+k] : 8'hxx, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n, sb;
      do_reset();
      done_delay = 10;
      tx_ready = 1'b1;
      sb = starts;
      n = done_cnt;
      push(4'h5, 8'h77);
      for (int c = 0; c < 1000 && done_cnt < n + 3; c++) @(posedge clk);
      checks++;
      if (done_cnt !== n + 3) begin
         errors++; $display("FAIL mid_wait got %0d dones exp 3", done_cnt - n);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checks++;
         if (tx_start !== 1'b0) begin
            errors++; $display("FAIL mid_start got %b exp 0", tx_start);
         end
      end
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (6) @(negedge clk);
      checks += 4;
      if (starts - sb !== 3) begin
         errors++; $display("FAIL mid_starts got %0d exp 3", starts - sb);
      end
      if (frame_count !== 8'h00) begin
         errors++; $display("FAIL mid_fc got %h exp 00", frame_count);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL mid_busy got %b exp 0", busy);
      end
      if (tx_data !== 8'h00) begin
         errors++; $display("FAIL mid_data got %h exp 00", tx_data);
      end
   endtask

   task automatic test_spurious();
      logic [7:0] e;
      int cb, sb;
      do_reset();
      done_delay = 10;
      tx_ready = 1'b1;
      cb = cap.size();
      sb = starts;
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      checks += 2;
      if (tx_start !== 1'b0 || starts != sb) begin
         errors++; $display("FAIL sp_idle_start got %0d starts exp 0", starts - sb);
      end
      if (busy !== 1'b0) begin
         errors++; $display("FAIL sp_idle_busy got %b exp 0", busy);
      end
      sample_valid = 1'b1;
      sample_id    = 4'h9;
      sample_data  = 8'hC4;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      tx_ready = 1'b0;
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (starts != sb || tx_start !== 1'b0) begin
         errors++; $display("FAIL sp_send_hold got %0d starts exp 0", starts - sb);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      wait_idle(2000, "sp_idle");
      checks += 2;
      if (starts - sb !== FLEN) begin
         errors++; $display("FAIL sp_starts got %0d exp %0d", starts - sb, FLEN);
      end
      if (frame_count !== 8'h01) begin
         errors++; $display("FAIL sp_fc got %h exp 01", frame_count);
      end
      for (int k = 0; k < FLEN; k++) begin
         e = exp_byte(4'h9, 8'hC4, k);
         checks++;
         if (cap.size() <= cb + k || cap[cb+k] !== e) begin
            errors++;
            $display("FAIL sp_byte%0d got %h exp %h", k,
                     (cap.size() > cb + k) ? cap[cb+k] : 8'hxx, e);
         end
      end
   endtask

   task automatic test_wrap();
      int pushed, sb, n;
      logic saw255;
      do_reset();
      done_delay = 1;
      tx_ready = 1'b1;
      pushed = 0;
      saw255 = 1'b0;
      sb = starts;
      n = 0;
      while (n < 40000 && !(pushed == 256 && !busy)) begin
         @(negedge clk);
         n++;
         if (frame_count == 8'hFF) saw255 = 1'b1;
         if (pushed < 256 && sample_ready) begin
            sample_valid = 1'b1;
            sample_id    = 4'(pushed);
            sample_data  = 8'(pushed);
            pushed++;
         end else begin
            sample_valid = 1'b0;
         end
      end
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL wrap_timeout busy=%b cycles %0d", busy, n);
      end
      if (saw255 !== 1'b1) begin
         errors++; $display("FAIL wrap_255 got %b exp 1", saw255);
      end
      if (frame_count !== 8'h00) begin
         errors++; $display("FAIL wrap_fc got %h exp 00", frame_count);
      end
      if (starts - sb !== 256 * FLEN) begin
         errors++; $display("FAIL wrap_starts got %0d exp %0d", starts - sb, 256 * FLEN);
      end
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL wrap_ovf got %b exp 0", overflow);
      end
   endtask

   initial begin
      test_reset();
      test_format();
      test_hex_letters();
      test_overflow();
      test_reset_mid_frame();
      test_spurious();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_framer.md
Name: sensor_framer

Overview:
- Downstream of the sensor front-ends (ALS SPI reader, future sensors); upstream of the FTDI UART transmitter.
- Buffers 8-bit sensor results tagged with a sensor ID.
- Serialises each result as an ASCII text frame, one byte at a time, over the FTDI byte handshake (initialize/ready/done).
- Replaces the top level's direct result-to-ftdi_data wiring, so several sensor results can be queued and sent without the main FSM waiting on each byte.

Parameters:
- FIFO_DEPTH, 4: sample entries buffered; power of two, minimum 2.
- ID_WIDTH, 4: width of sensor ID; IDs 0..15 only.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  reset; synchronous, active-low
- sample_valid  in  1  sample offered this cycle
- sample_id  in  ID_WIDTH  sensor ID of offered sample
- sample_data  in  8  sensor result byte
- sample_ready  out  1  FIFO can accept; equals !full
- tx_data  out  8  byte to FTDI, stable from tx_start until tx_done
- tx_start  out  1  one-cycle pulse; drives FTDI initialize
- tx_ready  in  1  FTDI idle
- tx_done  in  1  one-cycle pulse: FTDI finished current byte
- busy  out  1  frame in progress or FIFO non-empty
- overflow  out  1  sticky: a sample was offered while full
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO flushed.
  - FSM to IDLE.
  - tx_start=0, tx_data=0x00, overflow=0, frame_count=0, busy=0, sample_ready=1.
- Reset mid-frame aborts the frame: no further bytes, and no tx_done is counted. The FTDI byte already in flight finishes on its own; its tx_done is ignored.
- FIFO:
  - Push when sample_valid && sample_ready.
  - sample_ready comes from the registered occupancy. A push offered while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Push and pop in the same cycle while not full: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format: 7 bytes, uppercase hex.
  - 'S' (0x53)
  - hex(id)
  - ':' (0x3A)
  - hex(data[7:4])
  - hex(data[3:0])
  - CR (0x0D)
  - LF (0x0A)
  - hex(n) maps n<10 to 0x30+n, and n>=10 to 0x37+n.
- FSM, byte index idx:
  - IDLE: if FIFO non-empty and tx_ready, pop the head into the frame register, set idx=0, go to LOAD.
  - LOAD: compute tx_data for idx, go to SEND.
  - SEND: if tx_ready, pulse tx_start for one cycle and go to WAIT; otherwise hold.
  - WAIT: on tx_done, if idx is the last byte, increment frame_count and go to IDLE; else increment idx and go to LOAD. tx_done outside WAIT is ignored.
- Latency: a sample accepted at edge N into an empty FIFO, with tx_ready=1, gives tx_start high in the cycle after edge N+3.
- busy = (state != IDLE) || FIFO non-empty.
- tx_data holds its value between frames; it is not cleared.

Optional Feature:
- SENSOR_FRAMER_CHECKSUM_EN defined:
  - Two extra bytes, hex(chk[7:4]) and hex(chk[3:0]), are inserted between the data hex and CR. Frame is 9 bytes.
  - chk = {0, id} XOR data.
- Undefined: 7-byte frame, no checksum logic synthesised.

Test Plan:
- Format: push id=0, data=0x3F, tx_done returned 10 cycles after each tx_start -> tx_data sequence 53 30 3A 33 46 0D 0A, 7 tx_start pulses, frame_count=1, busy=0 at end.
- Hex letters: push id=2, data=0xA5 -> 53 32 3A 41 35 0D 0A. With checksum enabled -> 53 32 3A 41 35 41 37 0D 0A.
- Overflow: tx_ready=0, push 6 samples back-to-back -> first 4 accepted, sample_ready=0 after the 4th, overflow=1. Then tx_ready=1 -> 4 frames sent in push order, frame_count=4.
- Reset mid-frame: reset=0 for 1 cycle after the 3rd tx_done of a frame -> tx_start stays 0, frame_count=0, a late tx_done causes no tx_start, busy=0.
- Spurious handshake: tx_done pulsed while in IDLE and SEND -> no idx advance, byte sequence unchanged.
- Wrap: 256 frames -> frame_count returns to 0x00.
